// File: rtl/uart_pkg.sv
// Shared UART framing definitions: parser state encoding, start-of-frame
// byte and the payload sizing defaults used by both the rx parser and the
// tx framer.
package uart_pkg;

    localparam int               DBIT_DEFAULT    = 8;
    localparam int               MAX_LEN_DEFAULT = 16;
    localparam int               LEN_W_DEFAULT   = 5;
    localparam logic [7:0]       SOF_DEFAULT     = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_EMIT    = 3'd4
    } parser_state_e;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer for the frame parser: DEPTH x DBIT register array with one
// write port and one registered read port. The array itself is not reset;
// only the read register is, so the parser's pl_data output starts at zero.
module uart_frame_buf #(
    parameter int DBIT  = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [DBIT-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [DBIT-1:0] rdata
);

    logic [DBIT-1:0] mem [DEPTH];

    // Storage write; contents are don't-care until a frame fills them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read so the addressed byte appears one cycle after raddr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser behind the UART rx FIFO: SOF, LEN, LEN payload bytes, CHK.
// The payload is buffered and only streamed out once the XOR checksum of
// LEN and the payload matches; bad frames are dropped and counted.
// Optional inter-byte timeout is enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int              DBIT        = DBIT_DEFAULT,
    parameter int              MAX_LEN     = MAX_LEN_DEFAULT,
    parameter int              LEN_W       = LEN_W_DEFAULT,
    parameter logic [DBIT-1:0] SOF         = SOF_DEFAULT,
    parameter int              TIMEOUT_CYC = 1000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DBIT-1:0] r_data,
    input  logic            rx_empty,
    output logic            rd_uart,
    output logic [DBIT-1:0] pl_data,
    output logic            pl_valid,
    output logic            pl_last,
    input  logic            pl_ready,
    output logic            frame_ok,
    output logic            frame_err,
    output logic [7:0]      err_cnt
);

    localparam int AW = $clog2(MAX_LEN);

    parser_state_e   state_q, state_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [DBIT-1:0]  chk_q, chk_d;
    logic             pl_valid_q, pl_valid_d;
    logic             frame_ok_q, frame_ok_d;
    logic             frame_err_q, frame_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             consume;
    logic             err_event;
    logic             buf_we;
    logic [LEN_W-1:0] last_idx;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    assign consume  = reset && (state_q != ST_EMIT) && !rx_empty;
    assign rd_uart  = consume;
    assign last_idx = len_q - LEN_W'(1);
    assign pl_valid = pl_valid_q;
    assign pl_last  = pl_valid_q && (idx_q == last_idx);
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;

    // Next-state, buffer write and error accounting for the frame FSM.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        chk_d       = chk_q;
        pl_valid_d  = pl_valid_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        err_event   = 1'b0;
        buf_we      = 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
        tmo_d       = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (consume && (r_data == SOF)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (consume) begin
                    if ((r_data == '0) || (r_data > DBIT'(MAX_LEN))) begin
                        err_event = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        len_d   = r_data[LEN_W-1:0];
                        chk_d   = r_data;
                        idx_d   = '0;
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (consume) begin
                    buf_we = 1'b1;
                    chk_d  = chk_q ^ r_data;
                    idx_d  = idx_q + LEN_W'(1);
                    if (idx_q == last_idx) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (consume) begin
                    if (r_data == chk_q) begin
                        idx_d      = '0;
                        pl_valid_d = 1'b1;
                        state_d    = ST_EMIT;
                    end else begin
                        err_event = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_EMIT: begin
                if (pl_valid_q && pl_ready) begin
                    if (idx_q == last_idx) begin
                        pl_valid_d = 1'b0;
                        frame_ok_d = 1'b1;
                        idx_d      = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef UART_FRAME_TIMEOUT_EN
        if ((state_q == ST_LEN || state_q == ST_PAYLOAD || state_q == ST_CHK) && !consume) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                err_event = 1'b1;
                state_d   = ST_IDLE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
`endif
        if (err_event) begin
            frame_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // Parser state registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            chk_q       <= '0;
            pl_valid_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            chk_q       <= chk_d;
            pl_valid_q  <= pl_valid_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

`ifdef UART_FRAME_TIMEOUT_EN
    // Inter-byte stall counter, only live mid-frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // Read address follows the next index so pl_data is ready with pl_valid.
    uart_frame_buf #(
        .DBIT  (DBIT),
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .we    (buf_we),
        .waddr (idx_q[AW-1:0]),
        .wdata (r_data),
        .raddr (idx_d[AW-1:0]),
        .rdata (pl_data)
    );

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: a queue models the rx FIFO,
// expected payload bytes and frame events are queued when stimulus is
// issued, and a monitor pops and compares as the DUT produces them.
module tb_uart_frame_parser;

    logic       clk;
    logic       reset;
    logic [7:0] r_data;
    logic       rx_empty;
    logic       rd_uart;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_last;
    logic       pl_ready;
    logic       frame_ok;
    logic       frame_err;
    logic [7:0] err_cnt;

    logic [7:0] fifo [$];
    logic [8:0] exp_pl [$];
    bit         exp_ev [$];
    int         checks = 0;
    int         fails = 0;
    int         pop_count = 0;
    int         model_err = 0;
    bit         ready_toggle = 0;
    bit         stall_prev = 0;
    logic [7:0] held_data = 8'h00;

    uart_frame_parser #(.TIMEOUT_CYC(20)) dut (
        .clk       (clk),
        .reset     (reset),
        .r_data    (r_data),
        .rx_empty  (rx_empty),
        .rd_uart   (rd_uart),
        .pl_data   (pl_data),
        .pl_valid  (pl_valid),
        .pl_last   (pl_last),
        .pl_ready  (pl_ready),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Overall time guard
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] bytes [$]);
        foreach (bytes[i]) fifo.push_back(bytes[i]);
    endtask

    task automatic expectPayload(input logic [7:0] d, input bit last);
        exp_pl.push_back({last, d});
    endtask

    task automatic expectEvent(input bit is_err);
        exp_ev.push_back(is_err);
    endtask

    task automatic waitDrain(input int max_cyc, input string tag);
        bit done = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (fifo.size() == 0 && exp_pl.size() == 0 && exp_ev.size() == 0 &&
                !pl_valid && !frame_ok && !frame_err) begin
                done = 1;
                break;
            end
        end
        checks++;
        if (!done) begin
            fails++;
            $display("[TB] FAIL drain %s: got pending=%0d, expected 0", tag,
                     fifo.size() + exp_pl.size() + exp_ev.size());
            fifo.delete();
            exp_pl.delete();
            exp_ev.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // FIFO model: head presented at negedge, popped on rd_uart at posedge
    always @(negedge clk) begin
        rx_empty = (fifo.size() == 0);
        r_data   = rx_empty ? 8'h00 : fifo[0];
    end

    always @(posedge clk) begin
        if (rd_uart) begin
            if (fifo.size() > 0) void'(fifo.pop_front());
            pop_count++;
        end
    end

    // Downstream ready: constant high or toggling every cycle
    initial begin
        pl_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            pl_ready = ready_toggle ? ~pl_ready : 1'b1;
        end
    end

    // Monitor: compares payload handshakes and frame events against queues
    always @(negedge clk) begin
        if (reset) begin
            if (stall_prev) begin
                checkOutput("hold valid", {31'd0, pl_valid}, 32'd1);
                checkOutput("hold data", {24'd0, pl_data}, {24'd0, held_data});
            end
            stall_prev = pl_valid && !pl_ready;
            held_data  = pl_data;
            if (pl_valid) checkOutput("no pop while emitting", {31'd0, rd_uart}, 32'd0);
            if (pl_valid && pl_ready) begin
                if (exp_pl.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected payload: got %0h, expected none", pl_data);
                end else begin
                    logic [8:0] e;
                    e = exp_pl.pop_front();
                    checkOutput("pl_data", {24'd0, pl_data}, {24'd0, e[7:0]});
                    checkOutput("pl_last", {31'd0, pl_last}, {31'd0, e[8]});
                end
            end
            if (frame_ok || frame_err) begin
                if (exp_ev.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected event: got ok=%0d err=%0d, expected none", frame_ok, frame_err);
                end else begin
                    bit e;
                    e = exp_ev.pop_front();
                    checkOutput("frame_err", {31'd0, frame_err}, {31'd0, e});
                    checkOutput("frame_ok", {31'd0, frame_ok}, {31'd0, !e});
                    if (e && model_err < 255) model_err++;
                    checkOutput("err_cnt", {24'd0, err_cnt}, model_err);
                end
            end
        end else begin
            stall_prev = 0;
        end
    end

    initial begin
        logic [7:0] v [$];
        int pops_before;

        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset rd_uart", {31'd0, rd_uart}, 32'd0);
        checkOutput("reset pl_valid", {31'd0, pl_valid}, 32'd0);
        checkOutput("reset pl_last", {31'd0, pl_last}, 32'd0);
        checkOutput("reset frame_ok", {31'd0, frame_ok}, 32'd0);
        checkOutput("reset frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("reset pl_data", {24'd0, pl_data}, 32'd0);
        checkOutput("reset err_cnt", {24'd0, err_cnt}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] good frame");
        pops_before = pop_count;
        v = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h31};
        applyStimulus(v);
        expectPayload(8'h11, 0);
        expectPayload(8'h22, 1);
        expectEvent(0);
        waitDrain(100, "good");
        checkOutput("pop count", pop_count - pops_before, 32'd5);

        $display("[TB] bad checksum then good frame");
        v = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h30};
        applyStimulus(v);
        expectEvent(1);
        v = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h03};
        applyStimulus(v);
        expectPayload(8'h01, 0);
        expectPayload(8'h02, 0);
        expectPayload(8'h03, 1);
        expectEvent(0);
        waitDrain(100, "badchk");

        $display("[TB] length bounds");
        v = '{8'hA5, 8'h00};
        applyStimulus(v);
        expectEvent(1);
        v = '{8'hA5, 8'h11};
        applyStimulus(v);
        expectEvent(1);
        v = '{8'hA5, 8'h10};
        for (int i = 0; i < 16; i++) begin
            v.push_back(8'(i));
            expectPayload(8'(i), i == 15);
        end
        v.push_back(8'h10);
        applyStimulus(v);
        expectEvent(0);
        waitDrain(200, "lenbounds");

        $display("[TB] garbage then frame");
        v = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h7E, 8'h7F};
        applyStimulus(v);
        expectPayload(8'h7E, 1);
        expectEvent(0);
        waitDrain(100, "garbage");

        $display("[TB] backpressure with queued frame");
        ready_toggle = 1;
        v = '{8'hA5, 8'h03, 8'hA5, 8'h5A, 8'hC3, 8'h3F};
        applyStimulus(v);
        expectPayload(8'hA5, 0);
        expectPayload(8'h5A, 0);
        expectPayload(8'hC3, 1);
        expectEvent(0);
        v = '{8'hA5, 8'h01, 8'h42, 8'h43};
        applyStimulus(v);
        expectPayload(8'h42, 1);
        expectEvent(0);
        waitDrain(200, "backpressure");
        ready_toggle = 0;
        repeat (2) @(negedge clk);

        $display("[TB] reset mid-payload");
        v = '{8'hA5, 8'h04, 8'h11, 8'h22};
        applyStimulus(v);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        fifo.push_back(8'h55);
        repeat (2) @(negedge clk);
        checkOutput("midreset rd_uart", {31'd0, rd_uart}, 32'd0);
        checkOutput("midreset pl_valid", {31'd0, pl_valid}, 32'd0);
        checkOutput("midreset frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("midreset pl_data", {24'd0, pl_data}, 32'd0);
        checkOutput("midreset err_cnt", {24'd0, err_cnt}, 32'd0);
        model_err = 0;
        fifo.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        v = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h31};
        applyStimulus(v);
        expectPayload(8'h11, 0);
        expectPayload(8'h22, 1);
        expectEvent(0);
        waitDrain(100, "after reset");

`ifdef UART_FRAME_TIMEOUT_EN
        $display("[TB] inter-byte timeout");
        v = '{8'hA5, 8'h03, 8'h11};
        applyStimulus(v);
        expectEvent(1);
        waitDrain(100, "timeout");
        v = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
        applyStimulus(v);
        expectPayload(8'h7E, 1);
        expectEvent(0);
        waitDrain(100, "post timeout");
`endif

        $display("[TB] err_cnt saturation");
        for (int i = 0; i < 260; i++) begin
            v = '{8'hA5, 8'h00};
            applyStimulus(v);
            expectEvent(1);
        end
        waitDrain(2000, "saturation");
        checkOutput("err_cnt saturated", {24'd0, err_cnt}, 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
